// File: rtl/fft_twiddle_apply.sv
// Twiddle-multiply stage after the butterfly: the first half of each frame passes through,
// the second half is multiplied by successive twiddles, all with a fixed 3-cycle latency.
module fft_twiddle_apply #(
  parameter int WIDTH    = 16,
  parameter int SHIFT    = 14,
  parameter int LOG_HALF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_i,
  output logic             tw_req,
  input  logic [WIDTH-1:0] tw_r,
  input  logic [WIDTH-1:0] tw_i,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] out_i,
  output logic             out_last
);

  localparam int IW = LOG_HALF + 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam logic signed [WIDTH-1:0] W_ONE    = WIDTH'(1 << SHIFT);
  localparam logic        [IW-1:0]    IDX_LAST = '1;

  function automatic logic signed [PW-1:0] mul(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] ax, bx;
    ax = {{WIDTH{a[WIDTH-1]}}, a};
    bx = {{WIDTH{b[WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  function automatic logic signed [SW-1:0] ext(input logic signed [PW-1:0] p);
    return {p[PW-1], p};
  endfunction

  // Floor shift by SHIFT, then clamp to the WIDTH-bit signed range.
  function automatic logic signed [WIDTH-1:0] scale_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0]   v;
    logic        [SW-WIDTH:0] top;
    v   = s >>> SHIFT;
    top = v[SW-1:WIDTH-1];
    if (!v[SW-1] && (|top))
      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v[SW-1] && !(&top))
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return v[WIDTH-1:0];
  endfunction

  logic [IW-1:0]           idx;
  logic                    bypass, last_in;
  logic signed [WIDTH-1:0] w_r, w_i;

  assign bypass  = ~idx[LOG_HALF] | clear;
  assign tw_req  = in_valid & idx[LOG_HALF] & ~clear;
  assign last_in = (idx == IDX_LAST) & ~clear;
  assign w_r     = bypass ? W_ONE : $signed(tw_r);
  assign w_i     = bypass ? '0    : $signed(tw_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idx <= '0;
    else if (clear)
      idx <= in_valid ? IW'(1) : '0;
    else if (in_valid)
      idx <= idx + 1'b1;
  end

  // S1: operand capture
  logic                    vld_p1, last_p1;
  logic signed [WIDTH-1:0] ar_p1, ai_p1, wr_p1, wi_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      ar_p1   <= '0;
      ai_p1   <= '0;
      wr_p1   <= '0;
      wi_p1   <= '0;
    end else begin
      vld_p1  <= in_valid;
      last_p1 <= in_valid & last_in;
      if (in_valid) begin
        ar_p1 <= $signed(in_r);
        ai_p1 <= $signed(in_i);
        wr_p1 <= w_r;
        wi_p1 <= w_i;
      end
    end
  end

  // S2: partial products
  logic                 vld_p2, last_p2;
  logic signed [PW-1:0] rr_p2, ii_p2, ri_p2, ir_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      rr_p2   <= '0;
      ii_p2   <= '0;
      ri_p2   <= '0;
      ir_p2   <= '0;
    end else begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      if (vld_p1) begin
        rr_p2 <= mul(ar_p1, wr_p1);
        ii_p2 <= mul(ai_p1, wi_p1);
        ri_p2 <= mul(ar_p1, wi_p1);
        ir_p2 <= mul(ai_p1, wr_p1);
      end
    end
  end

  // S3: complex sum, scale and saturate; data holds while no valid
  logic signed [SW-1:0]    re_sum, im_sum;
  logic signed [WIDTH-1:0] re_p3, im_p3;
  logic                    vld_p3, last_p3;

  assign re_sum = ext(rr_p2) - ext(ii_p2);
  assign im_sum = ext(ri_p2) + ext(ir_p2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3  <= 1'b0;
      last_p3 <= 1'b0;
      re_p3   <= '0;
      im_p3   <= '0;
    end else begin
      vld_p3  <= vld_p2;
      last_p3 <= last_p2;
      if (vld_p2) begin
        re_p3 <= scale_sat(re_sum);
        im_p3 <= scale_sat(im_sum);
      end
    end
  end

  assign out_valid = vld_p3;
  assign out_last  = last_p3;
  assign out_r     = re_p3;
  assign out_i     = im_p3;

endmodule

// File: tb/tb_fft_twiddle_apply.sv
// Scoreboard bench for fft_twiddle_apply: a behavioural model predicts each output,
// which is queued with its due cycle and compared when the DUT presents it.
module tb_fft_twiddle_apply;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic        [15:0] in_r = '0, in_i = '0, tw_r = '0, tw_i = '0;
  logic               tw_req;
  logic               out_valid, out_last;
  logic signed [15:0] out_r, out_i;

  fft_twiddle_apply #(.WIDTH(16), .SHIFT(14), .LOG_HALF(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_r(in_r), .in_i(in_i), .tw_req(tw_req), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint r;
    longint i;
    bit     last;
    int     due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   m_idx = 0;
  int   twcnt = 0;
  int   outcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // One input cycle: apply inputs at the falling edge, check tw_req, queue the prediction.
  task automatic drive(input bit v, input int r, input int i,
                       input int twr, input int twi, input bit clr);
    bit     byp, req, lst;
    longint wr, wi, re, im;
    @(negedge clk);
    in_valid = v;
    in_r = 16'(r);
    in_i = 16'(i);
    tw_r = 16'(twr);
    tw_i = 16'(twi);
    clear = clr;
    #1;
    byp = clr || (m_idx < 4);
    req = v && !byp;
    lst = !clr && (m_idx == 7);
    check("tw_req", tw_req, req);
    if (req) twcnt++;
    if (v) begin
      wr = byp ? 16384 : twr;
      wi = byp ? 0 : twi;
      re = (longint'(r) * wr - longint'(i) * wi) >>> 14;
      im = (longint'(r) * wi + longint'(i) * wr) >>> 14;
      q.push_back('{r: sat16(re), i: sat16(im), last: lst, due: cyc + 3});
    end
    if (clr) m_idx = v ? 1 : 0;
    else if (v) m_idx = (m_idx + 1) % 8;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("out_r", out_r, e.r);
        check("out_i", out_i, e.i);
        check("out_last", out_last, e.last);
        check("latency", cyc, e.due);
        outcnt++;
      end
    end
  end

  initial begin
    // Reset held while inputs toggle: everything stays quiet
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_r = 16'($urandom);
      in_i = 16'($urandom);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_r", out_r, 0);
      check("rst_out_i", out_i, 0);
      check("rst_out_last", out_last, 0);
      check("rst_tw_req", tw_req, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;

    // Bypass half, then twiddled samples incl. saturation, then finish the frame
    drive(1, 100, -200, 5, 5, 0);
    drive(1, 32767, -32768, 5, 5, 0);
    drive(1, 0, 1, 5, 5, 0);
    drive(1, -5, 7, 5, 5, 0);
    drive(1, 1000, 2000, 0, -16384, 0);
    drive(1, 32767, 32767, 16384, -16384, 0);
    drive(1, -32768, -32768, -16384, -16384, 0);
    drive(1, 1234, -4321, 11585, -11585, 0);
    idle(4);

    // Two frames with random gaps
    twcnt = 0;
    outcnt = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1, $urandom_range(65535) - 32768, $urandom_range(65535) - 32768,
            $urandom_range(32768) - 16384, $urandom_range(32768) - 16384, 0);
      idle($urandom_range(2));
    end
    idle(4);
    check("tw_req_count", twcnt, 8);
    check("gap_out_count", outcnt, 16);

    // clear on the third sample of a frame
    drive(1, 11, 12, 100, 200, 0);
    drive(1, 13, 14, 100, 200, 0);
    drive(1, 15, 16, 9000, 9000, 1);
    drive(1, 17, 18, 9000, 9000, 0);
    idle(1);
    drive(1, 19, 20, 9000, 9000, 0);
    drive(1, 21, 22, 9000, 9000, 0);
    drive(1, 23, 24, 0, 16384, 0);
    check("clear_resume_req", tw_req, 1);
    drive(1, 25, 26, 8192, 8192, 0);
    idle(4);

    // Reset with samples in flight
    drive(1, 300, 400, 0, 0, 0);
    drive(1, 500, 600, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    q.delete();
    m_idx = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("midrst_quiet", outcnt, outcnt);
    drive(1, -77, 88, 0, 0, 0);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    check("drain_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
